// File: rtl/rgst_file_mp.sv
// Multi-port register file: one write port, two independent registered read ports
// with write-through bypass, synchronous clear and per-entry written flags.
module rgst_file_mp #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_e,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr,
    input  logic              rd_e_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_vld_a,
    input  logic              rd_e_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_vld_b,
    output logic [DEPTH-1:0]  vld
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [WIDTH-1:0]            rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0]            rd_data_b_q, rd_data_b_d;
    logic                        rd_vld_a_q, rd_vld_a_d;
    logic                        rd_vld_b_q, rd_vld_b_d;
    logic                        wr_ok;

    // A write lands only outside clear and never on a hardwired-zero entry 0.
    assign wr_ok = wr_e && !clr && !(ZERO_REG && (wr_addr == '0));

    // Read value seen by a port: same-cycle write data wins over stored contents.
    function automatic logic [WIDTH-1:0] rd_val(
        input logic [ADDR_W-1:0]              addr,
        input logic                           wr_hit_ok,
        input logic [ADDR_W-1:0]              waddr,
        input logic [WIDTH-1:0]               wdata,
        input logic [DEPTH-1:0][WIDTH-1:0]    mem
    );
        if (wr_hit_ok && (addr == waddr)) begin
            return wdata;
        end
        return mem[addr];
    endfunction

    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (clr) begin
            mem_d = '0;
            vld_d = '0;
        end else if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
            vld_d[wr_addr] = 1'b1;
        end
    end

    always_comb begin
        rd_vld_a_d  = rd_e_a;
        rd_data_a_d = rd_data_a_q;
        if (rd_e_a) begin
            rd_data_a_d = rd_val(rd_addr_a, wr_ok, wr_addr, wr_data, mem_q);
        end
    end

    always_comb begin
        rd_vld_b_d  = rd_e_b;
        rd_data_b_d = rd_data_b_q;
        if (rd_e_b) begin
            rd_data_b_d = rd_val(rd_addr_b, wr_ok, wr_addr, wr_data, mem_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q       <= '0;
            vld_q       <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_vld_a_q  <= 1'b0;
            rd_vld_b_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            vld_q       <= vld_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_vld_a_q  <= rd_vld_a_d;
            rd_vld_b_q  <= rd_vld_b_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_vld_a  = rd_vld_a_q;
    assign rd_vld_b  = rd_vld_b_q;
    assign vld       = vld_q;

endmodule

// File: tb/tb_rgst_file_mp.sv
// Directed bench for rgst_file_mp: default 8x4 instance plus a 16x8 ZERO_REG instance.
module tb_rgst_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       wr_e, clr, rd_e_a, rd_e_b;
    logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0] wr_data, rd_data_a, rd_data_b;
    logic       rd_vld_a, rd_vld_b;
    logic [3:0] vld;

    logic        z_wr_e, z_clr, z_rd_e_a, z_rd_e_b;
    logic [2:0]  z_wr_addr, z_rd_addr_a, z_rd_addr_b;
    logic [15:0] z_wr_data, z_rd_data_a, z_rd_data_b;
    logic        z_rd_vld_a, z_rd_vld_b;
    logic [7:0]  z_vld;

    int checks = 0;
    int failures = 0;

    rgst_file_mp dut (
        .clk(clk), .rst(rst), .wr_e(wr_e), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .rd_e_a(rd_e_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_vld_a(rd_vld_a), .rd_e_b(rd_e_b), .rd_addr_b(rd_addr_b),
        .rd_data_b(rd_data_b), .rd_vld_b(rd_vld_b), .vld(vld)
    );

    rgst_file_mp #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst), .wr_e(z_wr_e), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .clr(z_clr), .rd_e_a(z_rd_e_a), .rd_addr_a(z_rd_addr_a), .rd_data_a(z_rd_data_a),
        .rd_vld_a(z_rd_vld_a), .rd_e_b(z_rd_e_b), .rd_addr_b(z_rd_addr_b),
        .rd_data_b(z_rd_data_b), .rd_vld_b(z_rd_vld_b), .vld(z_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_e = 0; clr = 0; rd_e_a = 0; rd_e_b = 0;
        z_wr_e = 0; z_clr = 0; z_rd_e_a = 0; z_rd_e_b = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        idle();
        wr_e = 1; wr_addr = a; wr_data = d;
        step();
    endtask

    initial begin
        idle();
        wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0;
        z_wr_addr = 0; z_wr_data = 0; z_rd_addr_a = 0; z_rd_addr_b = 0;
        #1 rst = 1;
        #2;
        chk("rst_rd_data_a", rd_data_a, 0);
        chk("rst_rd_vld_a", rd_vld_a, 0);
        chk("rst_vld", vld, 0);
        // Requests while in reset must be ignored.
        wr_e = 1; wr_addr = 1; wr_data = 8'h99; rd_e_a = 1; rd_addr_a = 1;
        step();
        chk("rst_ignore_vld", vld, 0);
        chk("rst_ignore_rd_vld", rd_vld_a, 0);
        idle();
        rst = 0;

        // Basic write then read.
        wr(2, 8'hA5);
        idle(); rd_e_a = 1; rd_addr_a = 2;
        step();
        chk("rd_a_A5", rd_data_a, 8'hA5);
        chk("rd_vld_a_1", rd_vld_a, 1);
        chk("vld_0100", vld, 4'b0100);
        idle();
        step();
        chk("rd_vld_a_drop", rd_vld_a, 0);
        chk("rd_a_hold", rd_data_a, 8'hA5);

        // Unwritten entry reads as zero.
        rd_e_b = 1; rd_addr_b = 3;
        step();
        chk("rd_b_unwritten", rd_data_b, 0);
        chk("rd_vld_b_1", rd_vld_b, 1);

        // Bypass to both ports at once.
        idle();
        wr_e = 1; wr_addr = 1; wr_data = 8'h3C;
        rd_e_a = 1; rd_addr_a = 1; rd_e_b = 1; rd_addr_b = 1;
        step();
        chk("byp_a", rd_data_a, 8'h3C);
        chk("byp_b", rd_data_b, 8'h3C);

        // Fill and dual read.
        wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);
        idle(); rd_e_a = 1; rd_addr_a = 3; rd_e_b = 1; rd_addr_b = 0;
        step();
        chk("fill_a3", rd_data_a, 8'h44);
        chk("fill_b0", rd_data_b, 8'h11);
        chk("vld_1111", vld, 4'b1111);

        // Clear with concurrent write and read: pre-clear data, write dropped.
        idle();
        clr = 1; wr_e = 1; wr_addr = 0; wr_data = 8'hFF; rd_e_a = 1; rd_addr_a = 0;
        step();
        chk("clr_rd_old", rd_data_a, 8'h11);
        chk("clr_vld", vld, 0);
        idle(); rd_e_a = 1; rd_addr_a = 0;
        step();
        chk("clr_rd_zero", rd_data_a, 0);

        // Bypass over a zero entry must give the new data.
        idle();
        wr_e = 1; wr_addr = 2; wr_data = 8'h55; rd_e_b = 1; rd_addr_b = 2;
        step();
        chk("byp_b_55", rd_data_b, 8'h55);
        chk("vld_0100_b", vld, 4'b0100);

        // ZERO_REG instance.
        idle();
        z_wr_e = 1; z_wr_addr = 0; z_wr_data = 16'hBEEF; z_rd_e_a = 1; z_rd_addr_a = 0;
        step();
        chk("z_rd0", z_rd_data_a, 0);
        chk("z_rd_vld", z_rd_vld_a, 1);
        chk("z_vld0", z_vld, 0);
        idle();
        z_wr_e = 1; z_wr_addr = 5; z_wr_data = 16'h1234; z_rd_e_b = 1; z_rd_addr_b = 5;
        step();
        chk("z_byp5", z_rd_data_b, 16'h1234);
        chk("z_vld5", z_vld, 8'h20);
        idle(); z_rd_e_a = 1; z_rd_addr_a = 0;
        step();
        chk("z_rd0_again", z_rd_data_a, 0);

        // Async reset between edges.
        wr(3, 8'h77);
        idle(); rd_e_a = 1; rd_addr_a = 3;
        step();
        chk("pre_rst_rd", rd_data_a, 8'h77);
        #2 rst = 1;
        #1;
        chk("arst_rd_data_a", rd_data_a, 0);
        chk("arst_rd_vld_a", rd_vld_a, 0);
        chk("arst_rd_data_b", rd_data_b, 0);
        chk("arst_vld", vld, 0);
        chk("arst_z_vld", z_vld, 0);
        step();
        chk("arst_hold_vld", rd_vld_a, 0);
        idle();
        rst = 0;
        step();
        chk("post_rst_no_vld", rd_vld_a, 0);
        rd_e_a = 1; rd_addr_a = 3;
        step();
        chk("post_rst_rd", rd_data_a, 0);
        chk("post_rst_vld_a", rd_vld_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgst_file_mp.md
RGST_FILE_MP -- requirements
Module: rgst_file_mp

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of entries (power of two, >=2); ADDR_W = clog2(DEPTH).
REQ-003 Parameter ZERO_REG, default 0, when 1 entry 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_e  input  1  write enable.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 clr  input  1  synchronous clear of all entries and valid bits.
REQ-010 rd_e_a  input  1  read request, port A.
REQ-011 rd_addr_a  input  ADDR_W  read address, port A.
REQ-012 rd_data_a  output  WIDTH  registered read data, port A.
REQ-013 rd_vld_a  output  1  rd_data_a holds the result of a read issued the previous cycle.
REQ-014 rd_e_b, rd_addr_b, rd_data_b, rd_vld_b  same as REQ-010..013, port B.
REQ-015 vld  output  DEPTH  per-entry written flag; bit i = 1 once entry i has been written since the last reset or clr.

Function
REQ-016 Write: on a rising edge with wr_e=1 and clr=0, entry[wr_addr] <= wr_data and vld[wr_addr] <= 1.
REQ-017 Read latency is exactly 1 cycle: a request accepted at edge N drives rd_data_x/rd_vld_x=1 after edge N, held until edge N+1.
REQ-018 Cycle with rd_e_x=0: rd_vld_x <= 0; rd_data_x holds its previous value.
REQ-019 Write-through bypass: rd_e_x=1, wr_e=1, rd_addr_x==wr_addr, clr=0 in the same cycle -> rd_data_x <= wr_data (new data, not stale).
REQ-020 Both ports operate independently; both ports may read the same address in the same cycle, and both receive identical data.
REQ-021 Reading an entry never written returns 0.
REQ-022 clr=1 at an edge: all entries <= 0 and vld <= 0; any wr_e in that cycle is discarded.
REQ-023 Read concurrent with clr returns the pre-clear contents with no bypass; rd_vld_x follows REQ-017.
REQ-024 ZERO_REG=1: writes to address 0 are ignored, vld[0] stays 0, reads of address 0 return 0 (including the bypass case).
REQ-025 Addresses are always in range (power-of-two DEPTH); no out-of-range behaviour is defined.
REQ-026 vld is combinational from the flag registers and shows no glitches from read activity.

Reset
REQ-027 rst=1 immediately, regardless of clk: all entries = 0, vld = 0, rd_data_a = rd_data_b = 0, rd_vld_a = rd_vld_b = 0.
REQ-028 While rst=1, writes, reads and clr are ignored.
REQ-029 rst deasserted mid-operation: the first edge with rst=0 is a normal cycle; no read issued before reset produces rd_vld.

Verification
REQ-030 Reset, then write 0xA5 to addr 2; next cycle read A addr 2 -> rd_data_a=0xA5 and rd_vld_a=1 one cycle later; vld=4'b0100.
REQ-031 Same cycle: wr_e=1, wr_addr=1, wr_data=0x3C, rd_e_a=1, rd_addr_a=1, rd_e_b=1, rd_addr_b=1 -> both ports return 0x3C next cycle.
REQ-032 Fill all 4 entries (0x11, 0x22, 0x33, 0x44); read A addr 3 and B addr 0 together -> 0x44 / 0x11; vld=4'b1111.
REQ-033 With the entries filled, assert clr together with wr_e to addr 0 (0xFF) and read A addr 0 -> rd_data_a=0x11; next read of addr 0 -> 0x00; vld=0.
REQ-034 ZERO_REG=1, WIDTH=16, DEPTH=8: write 0xBEEF to addr 0 with a same-cycle read of addr 0 -> returns 0x0000; vld[0]=0.
REQ-035 Assert rst asynchronously between edges while rd_vld_a=1 and the entries are non-zero -> all outputs become 0 without waiting for a clk edge; reads after deassertion return 0.
